axi_read_arbiter_2: RTL and testbench
=====================================

# axi_read_arbiter_2

Sequential arbiter that owns the read path between two AXI masters and one slave port. It chooses which master may issue an AR transfer. It holds that choice until the final R beat of the burst completes. It drives the shared pointer that steers the AR and R channel multiplexers. It sits on the master side of the interconnect, upstream of the 1-to-2 channel muxes, and is the producer of the `pointer` those muxes consume.

## Interface
Parameters:
- `PTR_W`, default `AXI_POINTER_BITS`: width of the grant pointer.

Ports (name, direction, width, meaning):
- `ACLK` in 1: the single clock; all state changes on rising edge.
- `ARESETn` in 1: asynchronous, active-low reset.
- `arvalid0` in 1: ARVALID from master 0.
- `arvalid1` in 1: ARVALID from master 1.
- `arready_s` in 1: ARREADY returned by the slave port.
- `rvalid_s` in 1: RVALID from the slave port.
- `rlast_s` in 1: RLAST from the slave port.
- `rready_m` in 1: RREADY of the currently granted master, already muxed by `pointer`.
- `pointer` out PTR_W: grant select, a `Pointer` value (SEL0/SEL1).
- `ar_en` out 1: when high, the muxed ARVALID/ARREADY pass through; when low, both are forced to 0 at the muxes.
- `busy` out 1: a transaction is granted, i.e. state is not IDLE.

## Operation
- States are IDLE, ADDR and DATA, using a registered state and registered outputs.
- IDLE:
  - `ar_en`=0 and `busy`=0.
  - If any `arvalid` is high, grant per round-robin: the master not served last wins a tie. A single requester wins outright.
  - On a grant, load `pointer` and go to ADDR.
  - With no request, stay in IDLE and hold `pointer`.
- ADDR:
  - `ar_en`=1 and `busy`=1.
  - The AR handshake is `arvalid_sel & arready_s`, where `arvalid_sel` is the `arvalid` of the granted master. When it occurs, go to DATA.
  - A granted master that drops arvalid is a protocol violation. The arbiter holds the grant and does not re-arbitrate.
- DATA:
  - `ar_en`=0 and `busy`=1.
  - On `rvalid_s & rready_m & rlast_s`, set `last_served`=`pointer` and go to IDLE.
  - Non-last R beats do not change state.
- `last_served` is an internal register. Reset sets it to SEL1 so that master 0 has first priority.
- Only one read transaction is outstanding at a time. No AR is forwarded while in DATA.

## Timing
- Reset values: state=IDLE, `pointer`=SEL0, `ar_en`=0, `busy`=0, `last_served`=SEL1.
- Latency from arvalid to the grant:
  - arvalid sampled high in IDLE at edge N gives `ar_en`=1 and the new `pointer` after edge N.
  - The slave therefore sees ARVALID no earlier than one cycle after the master raises it.
- AR completion: an AR handshake at edge M gives state DATA and `ar_en`=0 after edge M. No second AR is accepted.
- Burst completion: the last R handshake at edge K gives IDLE after edge K.
  - A waiting request is granted at edge K+1, so there is exactly one idle bubble between bursts.
- Simultaneous requests in IDLE: round-robin decides, and the loser keeps its arvalid asserted and is granted after the winner's RLAST.
- `pointer` is stable from the grant through the last R beat. It never changes in ADDR or DATA.
- Reset asserted mid-burst immediately forces all reset values. Any in-flight burst is abandoned, and the slave is expected to be reset with it.

## Structure
- The shared AXI package (`AXI_define.svh`) holds the `Pointer` enum (SEL0, SEL1) and `AXI_POINTER_BITS`.
- A local typedef enum holds the FSM states (IDLE, ADDR, DATA); it is not exported.
- One optional sub-module, `rr_pick_2`, is a combinational 2-input round-robin picker:
  - Inputs: the two requests and `last_served`.
  - Output: the winning `Pointer`.
- The muxes are not instantiated here. The top-level interconnect wires `pointer` and `ar_en` into them.

## Test plan
- Reset then idle: hold ARESETn=0 for 3 cycles and release with no requests.
  - Required: `pointer`=SEL0, `ar_en`=0, `busy`=0 for 10 cycles.
- Single master, 4-beat burst: `arvalid1`=1, `arready_s`=1 in ADDR, then four R beats with rlast on the 4th.
  - Required: `pointer`=SEL1 one cycle after the request.
  - Required: `ar_en` high for exactly 1 cycle.
  - Required: IDLE after the 4th beat.
- Simultaneous requests: `arvalid0`=`arvalid1`=1 right after reset.
  - Required: the grant order is M0, then M1, then M0 again if both keep requesting.
  - Required: one idle cycle between bursts.
- Slave backpressure: keep `arready_s`=0 for 5 cycles in ADDR.
  - Required: `ar_en` stays 1 and `pointer` stays constant.
  - Required: DATA is entered after the edge where `arready_s` rises.
- R stall: rvalid with `rready_m`=0 and `rlast_s`=1 for 3 cycles.
  - Required: stay in DATA.
  - Required: IDLE after the cycle where `rready_m`=1.
- Reset mid-burst: assert ARESETn=0 in DATA while `pointer`=SEL1.
  - Required: immediately `pointer`=SEL0, `busy`=0.
  - Required: the next simultaneous request goes to M0.

Source files
------------

// File: rtl/axi_read_arbiter_2_pkg.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter_2_pkg
// Shared AXI read-path definitions used by the two-master read arbiter:
//   - AXI_POINTER_BITS : width of the grant pointer steering the AR/R muxes
//   - Pointer          : grant select encoding (SEL0 = master 0, SEL1 = master 1)
//   - other_ptr()      : returns the opposite master's pointer value
// ---------------------------------------------------------------------------
package axi_read_arbiter_2_pkg;

    localparam int AXI_POINTER_BITS = 1;

    typedef enum logic [AXI_POINTER_BITS-1:0] {
        SEL0 = 1'b0,
        SEL1 = 1'b1
    } Pointer;

    // Opposite master of the one given; used for the round-robin tie break.
    function automatic Pointer other_ptr(input Pointer p);
        Pointer r;
        if (p == SEL0) begin
            r = SEL1;
        end else begin
            r = SEL0;
        end
        return r;
    endfunction

endpackage : axi_read_arbiter_2_pkg

// File: rtl/axi_read_arbiter_2_chk.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter_2_chk
// Property checker for the read arbiter's registered outputs.
// Ports (all inputs):
//   ACLK, ARESETn : clock and asynchronous active-low reset
//   pointer       : grant pointer driven by the arbiter
//   ar_en         : AR pass-through enable
//   busy          : transaction granted
// ---------------------------------------------------------------------------
module axi_read_arbiter_2_chk #(
    parameter int PTR_W = 1
) (
    input logic             ACLK,
    input logic             ARESETn,
    input logic [PTR_W-1:0] pointer,
    input logic             ar_en,
    input logic             busy
);

    // AR may only be forwarded while a transaction is granted.
    a_ar_en_implies_busy: assert property (
        @(posedge ACLK) disable iff (!ARESETn) ar_en |-> busy
    );

    // The grant is frozen for the whole lifetime of a transaction.
    a_pointer_stable: assert property (
        @(posedge ACLK) disable iff (!ARESETn)
        (busy && $past(busy)) |-> (pointer == $past(pointer))
    );

endmodule : axi_read_arbiter_2_chk

// File: rtl/axi_read_arbiter_2_rr_pick_2.sv
// ---------------------------------------------------------------------------
// rr_pick_2
// Combinational two-input round-robin picker.
// Ports:
//   req0, req1  in  : request lines of master 0 / master 1
//   last_served in  : master that completed the most recent burst
//   winner      out : selected master; on a tie the master not served last
//                     wins, a single requester wins outright. With no request
//                     the output is SEL0 and is ignored by the caller.
// ---------------------------------------------------------------------------
module rr_pick_2
    import axi_read_arbiter_2_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  Pointer last_served,
    output Pointer winner
);

    // Priority selection between the two requesters.
    always_comb begin
        winner = SEL0;
        case ({req1, req0})
            2'b01:   winner = SEL0;
            2'b10:   winner = SEL1;
            2'b11:   winner = other_ptr(last_served);
            default: winner = SEL0;
        endcase
    end

endmodule : rr_pick_2

// File: rtl/axi_read_arbiter_2.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter_2
// Read-path arbiter between two AXI masters and one slave port. Grants one
// master per read burst (round-robin), holds the grant until the last R beat
// and drives the pointer steering the downstream AR/R channel muxes.
// Parameters:
//   PTR_W      : width of the grant pointer
// Ports:
//   ACLK       in  : clock, rising edge
//   ARESETn    in  : asynchronous active-low reset
//   arvalid0   in  : ARVALID of master 0
//   arvalid1   in  : ARVALID of master 1
//   arready_s  in  : ARREADY from the slave port
//   rvalid_s   in  : RVALID from the slave port
//   rlast_s    in  : RLAST from the slave port
//   rready_m   in  : RREADY of the granted master (already muxed)
//   pointer    out : grant select (SEL0/SEL1), registered
//   ar_en      out : enables the muxed ARVALID/ARREADY, registered
//   busy       out : a transaction is granted, registered
// ---------------------------------------------------------------------------
module axi_read_arbiter_2
    import axi_read_arbiter_2_pkg::*;
#(
    parameter int PTR_W = AXI_POINTER_BITS
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             arvalid0,
    input  logic             arvalid1,
    input  logic             arready_s,
    input  logic             rvalid_s,
    input  logic             rlast_s,
    input  logic             rready_m,
    output logic [PTR_W-1:0] pointer,
    output logic             ar_en,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state_r;
    Pointer pointer_r;
    Pointer last_served_r;
    Pointer pick_s;
    logic   ar_en_r;
    logic   busy_r;
    logic   any_req_s;
    logic   arvalid_sel_s;
    logic   ar_hs_s;
    logic   r_last_hs_s;

    rr_pick_2 u_pick (
        .req0        (arvalid0),
        .req1        (arvalid1),
        .last_served (last_served_r),
        .winner      (pick_s)
    );

    // ARVALID of the currently granted master.
    always_comb begin
        arvalid_sel_s = 1'b0;
        if (pointer_r == SEL1) begin
            arvalid_sel_s = arvalid1;
        end else begin
            arvalid_sel_s = arvalid0;
        end
    end

    assign any_req_s   = arvalid0 | arvalid1;
    assign ar_hs_s     = arvalid_sel_s & arready_s;
    assign r_last_hs_s = rvalid_s & rready_m & rlast_s;

    // Grant FSM with registered outputs; pointer only loads in IDLE so it is
    // frozen from grant through the last R beat. A granted master dropping
    // ARVALID simply leaves the FSM waiting in ADDR.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r       <= IDLE;
            pointer_r     <= SEL0;
            last_served_r <= SEL1;
            ar_en_r       <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        state_r   <= ADDR;
                        pointer_r <= pick_s;
                        ar_en_r   <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        ar_en_r   <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end
                ADDR: begin
                    if (ar_hs_s) begin
                        state_r <= DATA;
                        ar_en_r <= 1'b0;
                    end else begin
                        state_r <= ADDR;
                        ar_en_r <= 1'b1;
                    end
                    busy_r <= 1'b1;
                end
                DATA: begin
                    ar_en_r <= 1'b0;
                    if (r_last_hs_s) begin
                        state_r       <= IDLE;
                        last_served_r <= pointer_r;
                        busy_r        <= 1'b0;
                    end else begin
                        state_r <= DATA;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a safe idle state.
                    state_r       <= IDLE;
                    pointer_r     <= SEL0;
                    last_served_r <= SEL1;
                    ar_en_r       <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign pointer = PTR_W'(pointer_r);
    assign ar_en   = ar_en_r;
    assign busy    = busy_r;

    axi_read_arbiter_2_chk #(
        .PTR_W (PTR_W)
    ) u_chk (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .pointer (pointer),
        .ar_en   (ar_en),
        .busy    (busy)
    );

endmodule : axi_read_arbiter_2

// File: tb/tb_axi_read_arbiter_2.sv
// ---------------------------------------------------------------------------
// tb_axi_read_arbiter_2
// Self-checking bench for axi_read_arbiter_2. Expected grants are queued when
// requests are driven and popped when the arbiter raises ar_en.
// ---------------------------------------------------------------------------
module tb_axi_read_arbiter_2;
    import axi_read_arbiter_2_pkg::*;

    logic       ACLK;
    logic       ARESETn;
    logic       arvalid0;
    logic       arvalid1;
    logic       arready_s;
    logic       rvalid_s;
    logic       rlast_s;
    logic       rready_m;
    logic [0:0] pointer;
    logic       ar_en;
    logic       busy;

    int n_cmp;
    int n_err;
    Pointer exp_q[$];

    axi_read_arbiter_2 dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .arvalid0  (arvalid0),
        .arvalid1  (arvalid1),
        .arready_s (arready_s),
        .rvalid_s  (rvalid_s),
        .rlast_s   (rlast_s),
        .rready_m  (rready_m),
        .pointer   (pointer),
        .ar_en     (ar_en),
        .busy      (busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic apply_reset();
        ARESETn = 1'b0;
        repeat (3) @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    // Waits (bounded) for ar_en; returns cycles waited, 0 on timeout.
    task automatic wait_grant(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge ACLK);
            if (ar_en === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    // Pops the expected grant and compares it to the current pointer.
    task automatic pop_and_check_grant(input string name);
        Pointer e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: grant seen with empty scoreboard, pointer=%0d", name, pointer);
        end else begin
            e = exp_q.pop_front();
            if (pointer !== e) begin
                n_err++;
                $display("FAIL %s: pointer=%0d required=%0d", name, pointer, e);
            end
        end
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        repeat (3) @(negedge ACLK);
        n_cmp++;
        if (pointer !== 1'b0 || ar_en !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: ptr=%0d ar_en=%0d busy=%0d required 0/0/0", pointer, ar_en, busy);
        end
        ARESETn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            n_cmp++;
            if (pointer !== 1'b0 || ar_en !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: ptr=%0d ar_en=%0d busy=%0d required 0/0/0", i, pointer, ar_en, busy);
            end
        end
    endtask

    task automatic test_single_burst();
        int cyc;
        arvalid1  = 1'b1;
        arready_s = 1'b1;
        exp_q.push_back(SEL1);
        wait_grant(cyc);
        n_cmp++;
        if (cyc != 1) begin
            n_err++;
            $display("FAIL single_latency: cycles=%0d required=1", cyc);
        end
        if (cyc != 0) pop_and_check_grant("single_grant");
        @(negedge ACLK);
        arvalid1  = 1'b0;
        arready_s = 1'b0;
        n_cmp++;
        if (ar_en !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_ar_pulse: ar_en=%0d busy=%0d required 0/1", ar_en, busy);
        end
        for (int b = 0; b < 4; b++) begin
            rvalid_s = 1'b1;
            rready_m = 1'b1;
            rlast_s  = (b == 3);
            @(negedge ACLK);
            n_cmp++;
            if (b < 3) begin
                if (busy !== 1'b1 || pointer !== 1'b1) begin
                    n_err++;
                    $display("FAIL single_beat[%0d]: busy=%0d ptr=%0d required 1/1", b, busy, pointer);
                end
            end else begin
                if (busy !== 1'b0 || ar_en !== 1'b0) begin
                    n_err++;
                    $display("FAIL single_done: busy=%0d ar_en=%0d required 0/0", busy, ar_en);
                end
            end
        end
        rvalid_s = 1'b0;
        rready_m = 1'b0;
        rlast_s  = 1'b0;
    endtask

    task automatic test_simultaneous();
        int cyc;
        apply_reset();
        arvalid0  = 1'b1;
        arvalid1  = 1'b1;
        arready_s = 1'b1;
        exp_q.push_back(SEL0);
        exp_q.push_back(SEL1);
        exp_q.push_back(SEL0);
        for (int g = 0; g < 3; g++) begin
            wait_grant(cyc);
            n_cmp++;
            if (cyc != 1) begin
                n_err++;
                $display("FAIL simul_gap[%0d]: cycles=%0d required=1", g, cyc);
            end
            if (cyc == 0) break;
            pop_and_check_grant("simul_grant");
            @(negedge ACLK);
            rvalid_s = 1'b1;
            rready_m = 1'b1;
            rlast_s  = 1'b0;
            @(negedge ACLK);
            rlast_s  = 1'b1;
            @(negedge ACLK);
            if (g == 2) begin
                arvalid0 = 1'b0;
                arvalid1 = 1'b0;
            end
            rvalid_s = 1'b0;
            rready_m = 1'b0;
            rlast_s  = 1'b0;
            n_cmp++;
            if (busy !== 1'b0 || ar_en !== 1'b0) begin
                n_err++;
                $display("FAIL simul_bubble[%0d]: busy=%0d ar_en=%0d required 0/0", g, busy, ar_en);
            end
        end
        arvalid0  = 1'b0;
        arvalid1  = 1'b0;
        arready_s = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_r_stall();
        int cyc;
        arvalid1  = 1'b1;
        arready_s = 1'b1;
        exp_q.push_back(SEL1);
        wait_grant(cyc);
        if (cyc == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rstall_grant: timeout cycles=%0d required>0", cyc);
        end else begin
            pop_and_check_grant("rstall_grant");
        end
        @(negedge ACLK);
        arvalid1  = 1'b0;
        arready_s = 1'b0;
        rvalid_s  = 1'b1;
        rlast_s   = 1'b1;
        rready_m  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            n_cmp++;
            if (busy !== 1'b1 || ar_en !== 1'b0) begin
                n_err++;
                $display("FAIL rstall_hold[%0d]: busy=%0d ar_en=%0d required 1/0", i, busy, ar_en);
            end
        end
        rready_m = 1'b1;
        @(negedge ACLK);
        rvalid_s = 1'b0;
        rlast_s  = 1'b0;
        rready_m = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rstall_done: busy=%0d required=0", busy);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        arvalid0  = 1'b1;
        arready_s = 1'b0;
        exp_q.push_back(SEL0);
        wait_grant(cyc);
        if (cyc == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL bp_grant: timeout cycles=%0d required>0", cyc);
        end else begin
            pop_and_check_grant("bp_grant");
        end
        // A competing request during ADDR must not move the grant.
        arvalid1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            n_cmp++;
            if (ar_en !== 1'b1 || pointer !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: ar_en=%0d ptr=%0d busy=%0d required 1/0/1", i, ar_en, pointer, busy);
            end
        end
        arready_s = 1'b1;
        @(negedge ACLK);
        arvalid0  = 1'b0;
        arvalid1  = 1'b0;
        arready_s = 1'b0;
        n_cmp++;
        if (ar_en !== 1'b0 || busy !== 1'b1 || pointer !== 1'b0) begin
            n_err++;
            $display("FAIL bp_data: ar_en=%0d busy=%0d ptr=%0d required 0/1/0", ar_en, busy, pointer);
        end
        rvalid_s = 1'b1;
        rready_m = 1'b1;
        rlast_s  = 1'b1;
        @(negedge ACLK);
        rvalid_s = 1'b0;
        rready_m = 1'b0;
        rlast_s  = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_done: busy=%0d required=0", busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        int cyc;
        arvalid1  = 1'b1;
        arready_s = 1'b1;
        exp_q.push_back(SEL1);
        wait_grant(cyc);
        if (cyc == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rmid_grant: timeout cycles=%0d required>0", cyc);
        end else begin
            pop_and_check_grant("rmid_grant");
        end
        @(negedge ACLK);
        arvalid1  = 1'b0;
        arready_s = 1'b0;
        rvalid_s  = 1'b1;
        rready_m  = 1'b1;
        rlast_s   = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || pointer !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_in_data: busy=%0d ptr=%0d required 1/1", busy, pointer);
        end
        ARESETn = 1'b0;
        #1;
        n_cmp++;
        if (pointer !== 1'b0 || busy !== 1'b0 || ar_en !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_async: ptr=%0d busy=%0d ar_en=%0d required 0/0/0", pointer, busy, ar_en);
        end
        rvalid_s = 1'b0;
        rready_m = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETn   = 1'b1;
        arvalid0  = 1'b1;
        arvalid1  = 1'b1;
        arready_s = 1'b1;
        exp_q.push_back(SEL0);
        wait_grant(cyc);
        if (cyc == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rmid_regrant: timeout cycles=%0d required>0", cyc);
        end else begin
            pop_and_check_grant("rmid_regrant");
        end
        arvalid0  = 1'b0;
        arvalid1  = 1'b0;
        arready_s = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        ARESETn   = 1'b0;
        arvalid0  = 1'b0;
        arvalid1  = 1'b0;
        arready_s = 1'b0;
        rvalid_s  = 1'b0;
        rlast_s   = 1'b0;
        rready_m  = 1'b0;
        @(negedge ACLK);
        test_reset();
        test_single_burst();
        test_simultaneous();
        test_r_stall();
        test_backpressure();
        test_reset_mid_burst();
        repeat (2) @(negedge ACLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_axi_read_arbiter_2
